serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 103 ++++++++++
 tb/tb_serial_add_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice, one operand bit per clock, LSB first.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s, carry_next, last_bit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and the combinational full-adder slice
  always_comb begin
    state_next = state;
    bit_s      = a_sr[0] ^ b_sr[0] ^ carry;
    carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    last_bit   = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand shifters, carry flop, serial sum reassembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      co     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_sr <= {bit_s, sum_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= carry_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) co <= carry_next;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ovf <= 1'b0;
    else if (state == RUN && last_bit) ovf <= carry ^ carry_next;
  end
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_sr;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: an 8-bit instance for directed vectors and a
// 2-bit instance for exhaustive slice coverage; ovf is checked when SERIAL_ADD_OVF_EN is set.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid8 = 1'b0, out_ready8 = 1'b1, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, co8, busy8;
  logic [7:0] sum8;
  logic       in_valid2 = 1'b0, out_ready2 = 1'b1, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       in_ready2, out_valid2, co2, busy2;
  logic [1:0] sum2;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf8, ovf2;
`endif

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .co(co8), .busy(busy8)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .co(co2), .busy(busy2)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf2)
`endif
  );

  typedef struct packed {
    logic       ovf;
    logic       co;
    logic [7:0] sum;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  int pass_cnt = 0, total_cnt = 0;
  int accepts8 = 0, shakes8 = 0, accepts2 = 0, shakes2 = 0;
  int cyc = 0, last_acc2 = -1;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Monitors: pop the scoreboard whenever a result handshake is about to happen
  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      shakes8++;
      if (q8.size() == 0) checkOutput("w8_unexpected_output", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        checkOutput("w8_sum", 32'(sum8), 32'(e.sum));
        checkOutput("w8_co", 32'(co8), 32'(e.co));
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("w8_ovf", 32'(ovf8), 32'(e.ovf));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid2 && out_ready2) begin
      shakes2++;
      if (q2.size() == 0) checkOutput("w2_unexpected_output", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q2.pop_front();
        checkOutput("w2_sum", 32'(sum2), 32'(e.sum));
        checkOutput("w2_co", 32'(co2), 32'(e.co));
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("w2_ovf", 32'(ovf2), 32'(e.ovf));
`endif
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                               input logic [7:0] esum, input logic eco, input logic eovf);
    int n;
    exp_t e;
    @(posedge clk); #1;
    a8 = av; b8 = bv; cin8 = cv; in_valid8 = 1'b1;
    n = 0;
    while (!in_ready8 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready8) begin
      checkOutput("w8_accept_timeout", 32'd0, 32'd1);
      in_valid8 = 1'b0;
      return;
    end
    e.sum = esum; e.co = eco; e.ovf = eovf;
    q8.push_back(e);
    accepts8++;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
  endtask

  task automatic applyStimulusNarrow(input logic [1:0] av, input logic [1:0] bv, input logic cv);
    int n;
    exp_t e;
    logic [2:0] t;
    logic c1;
    @(posedge clk); #1;
    a2 = av; b2 = bv; cin2 = cv; in_valid2 = 1'b1;
    n = 0;
    while (!in_ready2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready2) begin
      checkOutput("w2_accept_timeout", 32'd0, 32'd1);
      in_valid2 = 1'b0;
      return;
    end
    t  = {1'b0, av} + {1'b0, bv} + {2'b00, cv};
    c1 = (av[0] & bv[0]) | (av[0] & cv) | (bv[0] & cv);
    e.sum = {6'b0, t[1:0]}; e.co = t[2]; e.ovf = c1 ^ t[2];
    q2.push_back(e);
    accepts2++;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    if (last_acc2 >= 0) checkOutput("w2_b2b_gap", 32'(cyc - last_acc2), 32'd4);
    last_acc2 = cyc;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid8) checkOutput("w8_result_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    $display("[TB] starting serial_add_ctrl bench");
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_out_valid", 32'(out_valid8), 32'd0);
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready8), 32'd1);
    checkOutput("rst_sum", 32'(sum8), 32'h00);
    checkOutput("rst_co", 32'(co8), 32'd0);
    checkOutput("rst_w2_in_ready", 32'(in_ready2), 32'd1);

    applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    waitResult(lat);
    checkOutput("basic_latency", 32'(lat), 32'd8);
    @(posedge clk); #1;
    checkOutput("basic_out_valid_drop", 32'(out_valid8), 32'd0);
    repeat (2) @(posedge clk); #1;
    checkOutput("idle_sum_hold", 32'(sum8), 32'h00);
    checkOutput("idle_co_hold", 32'(co8), 32'd1);

    applyStimulus(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    applyStimulus(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

    // Backpressure: hold the result for five cycles and poke in_valid meanwhile
    @(posedge clk); #1;
    while (busy8) begin @(posedge clk); #1; end
    out_ready8 = 1'b0;
    applyStimulus(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0);
    waitResult(lat);
    checkOutput("bp_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_out_valid", 32'(out_valid8), 32'd1);
      checkOutput("bp_sum_stable", 32'(sum8), 32'h4C);
      checkOutput("bp_co_stable", 32'(co8), 32'd0);
      checkOutput("bp_in_ready", 32'(in_ready8), 32'd0);
      if (i == 2) begin
        a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
      end else begin
        in_valid8 = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_in_ready", 32'(in_ready8), 32'd1);
    checkOutput("bp_release_out_valid", 32'(out_valid8), 32'd0);

    // Reset in the middle of an operation
    applyStimulus(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid8), 32'd0);
    checkOutput("midrst_busy", 32'(busy8), 32'd0);
    checkOutput("midrst_co", 32'(co8), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready8), 32'd1);
    q8.delete();
    accepts8--;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    applyStimulus(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    waitResult(lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd8);

    // Exhaustive 2-bit slice coverage, back-to-back
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      applyStimulusNarrow(v[4:3], v[2:1], v[0]);
    end

    for (int n = 0; n < 50 && (q8.size() != 0 || q2.size() != 0); n++) @(posedge clk);
    @(posedge clk); #1;
    checkOutput("w8_scoreboard_empty", 32'(q8.size()), 32'd0);
    checkOutput("w2_scoreboard_empty", 32'(q2.size()), 32'd0);
    checkOutput("w8_handshakes", 32'(shakes8), 32'(accepts8));
    checkOutput("w2_handshakes", 32'(shakes2), 32'(accepts2));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
